// File: rtl/relu_seq_ctrl_if.sv
// relu_seq_ctrl_if
//   Bundles the control, status, buffer and ReLU-unit signals of
//   relu_seq_ctrl. ADDR_W must match the controller's ADDR_W.
//   Ports (slave = controller view):
//     in : start, abort, src_addr, dst_addr, length, rd_data, relu_out
//     out: busy, done, neg_count, rd_en, rd_addr, relu_x,
//          wr_en, wr_addr, wr_data
interface relu_seq_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   neg_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [31:0]       relu_x;
  logic [31:0]       relu_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output start, abort, src_addr, dst_addr, length, rd_data, relu_out,
    input  busy, done, neg_count, rd_en, rd_addr, relu_x,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, abort, src_addr, dst_addr, length, rd_data, relu_out,
    output busy, done, neg_count, rd_en, rd_addr, relu_x,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl
//   Streams a batch of 32-bit float words from a feature-map buffer through
//   an external ReLU unit of RELU_LAT registered stages and writes the
//   results back to a destination region. One word per cycle, no bubbles.
//   Counts the words with the sign bit set.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : relu_seq_ctrl_if.slave (control/status, buffer read/write,
//             ReLU unit x/out)
module relu_seq_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int RELU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  relu_seq_ctrl_if.slave  bus
);

  // One stage for the buffer read latency plus RELU_LAT for the ReLU unit.
  localparam int DEPTH = RELU_LAT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_neg;

  // r_vld[k] set means word r_pidx[k] is k+1 cycles past its read strobe.
  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_pidx [DEPTH];

  logic              w_accept;
  logic              w_abort;
  logic              w_rd;
  logic              w_wr;
  logic              w_last_rd;

  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_abort   = bus.abort && ((r_state == RUN) || (r_state == DRAIN));
  assign w_rd      = (r_state == RUN);
  assign w_wr      = r_vld[DEPTH-1];
  assign w_last_rd = (r_idx == (r_len - (ADDR_W+1)'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort is only honoured while a batch is in flight,
  // so start always wins in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = (bus.length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_last_rd) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once only the final write remains in the last stage.
        if (bus.abort) begin
          w_next = IDLE;
        end else if (~|r_vld[DEPTH-2:0]) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Batch parameters, read index and negative-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_neg <= '0;
    end else if (w_accept) begin
      r_src <= bus.src_addr;
      r_dst <= bus.dst_addr;
      r_len <= bus.length;
      r_idx <= '0;
      r_neg <= '0;
    end else begin
      if (w_rd) begin
        r_idx <= r_idx + (ADDR_W+1)'(1);
      end
      if (r_vld[0] && bus.rd_data[31]) begin
        r_neg <= r_neg + (ADDR_W+1)'(1);
      end
    end
  end

  // Valid/index pipeline, flushed by abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_pidx[k] <= '0;
      end
    end else if (w_abort) begin
      r_vld <= '0;
    end else begin
      r_vld     <= {r_vld[DEPTH-2:0], w_rd};
      r_pidx[0] <= r_idx[ADDR_W-1:0];
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_pidx[k] <= r_pidx[k-1];
      end
    end
  end

  // Outputs are gated by their strobes so that reset drives them all to 0.
  assign bus.busy      = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done      = (r_state == DONE);
  assign bus.neg_count = r_neg;
  assign bus.rd_en     = w_rd;
  assign bus.rd_addr   = w_rd ? (r_src + r_idx[ADDR_W-1:0]) : '0;
  assign bus.relu_x    = r_vld[0] ? bus.rd_data : '0;
  assign bus.wr_en     = w_wr;
  assign bus.wr_addr   = w_wr ? (r_dst + r_pidx[DEPTH-1]) : '0;
  assign bus.wr_data   = w_wr ? bus.relu_out : '0;

endmodule

// File: tb/tb_relu_seq_ctrl.sv
`timescale 1ns/1ps
// Runs two controllers side by side (RELU_LAT = 1 and 3) from the same
// stimulus, each with its own buffer read port and ReLU pipeline, and checks
// the logged read/write/done events against a timing model of the batch.
module tb_relu_seq_ctrl;
  localparam int AW = 10;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic          start;
  logic          abort;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;

  logic [31:0] mem [1<<AW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Negative numbers, including -0, clamp to +0.
  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int LAT = (g == 0) ? 1 : 3;

    relu_seq_ctrl_if #(.ADDR_W(AW)) ifc ();

    logic [31:0] rpipe [LAT];
    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];
    int  busy_n = 0;

    relu_seq_ctrl #(.ADDR_W(AW), .RELU_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );

    assign ifc.start    = start;
    assign ifc.abort    = abort;
    assign ifc.src_addr = src;
    assign ifc.dst_addr = dst;
    assign ifc.length   = len;
    assign ifc.relu_out = rpipe[LAT-1];

    always @(posedge clk) begin
      ifc.rd_data <= mem[ifc.rd_addr];
      rpipe[0]    <= relu(ifc.relu_x);
      for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end

    always @(negedge clk) begin
      if (clr) begin
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_n = 0;
      end else begin
        if (ifc.rd_en) rd_q.push_back(ev_t'{cyc, ifc.rd_addr, 32'h0});
        if (ifc.wr_en) wr_q.push_back(ev_t'{cyc, ifc.wr_addr, ifc.wr_data});
        if (ifc.done)  done_q.push_back(cyc);
        if (ifc.busy)  busy_n = busy_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " L1 busy"},    h[0].ifc.busy,      0);
    chk({tag, " L1 done"},    h[0].ifc.done,      0);
    chk({tag, " L1 rd_en"},   h[0].ifc.rd_en,     0);
    chk({tag, " L1 wr_en"},   h[0].ifc.wr_en,     0);
    chk({tag, " L1 rd_addr"}, h[0].ifc.rd_addr,   0);
    chk({tag, " L1 wr_addr"}, h[0].ifc.wr_addr,   0);
    chk({tag, " L1 wr_data"}, h[0].ifc.wr_data,   0);
    chk({tag, " L1 neg"},     h[0].ifc.neg_count, 0);
    chk({tag, " L3 busy"},    h[1].ifc.busy,      0);
    chk({tag, " L3 done"},    h[1].ifc.done,      0);
    chk({tag, " L3 rd_en"},   h[1].ifc.rd_en,     0);
    chk({tag, " L3 wr_en"},   h[1].ifc.wr_en,     0);
    chk({tag, " L3 rd_addr"}, h[1].ifc.rd_addr,   0);
    chk({tag, " L3 wr_addr"}, h[1].ifc.wr_addr,   0);
    chk({tag, " L3 wr_data"}, h[1].ifc.wr_data,   0);
    chk({tag, " L3 neg"},     h[1].ifc.neg_count, 0);
  endtask

  // Start accepted in cycle c0: read i in c0+1+i, write i in c0+2+lat+i,
  // done the cycle after the last write (c0+1 for an empty batch).
  task automatic check_batch(input string tag, input int lat, input int c0,
                             input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [AW:0] n, input ev_t rq[$], input ev_t wq[$],
                             input int dq[$], input int bn, input logic [AW:0] neg);
    int exp_neg;
    exp_neg = 0;
    chk({tag, " read count"},  rq.size(), n);
    chk({tag, " write count"}, wq.size(), n);
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] a;
      a = s + AW'(i);
      if (mem[a][31]) exp_neg++;
      if (i < rq.size()) chk({tag, " read"}, rq[i], ev_t'{c0 + 1 + i, a, 32'h0});
      if (i < wq.size())
        chk({tag, " write"}, wq[i], ev_t'{c0 + 2 + lat + i, d + AW'(i), relu(mem[a])});
    end
    chk({tag, " done count"}, dq.size(), 1);
    if (dq.size() > 0)
      chk({tag, " done cycle"}, dq[0], (n == 0) ? c0 + 1 : c0 + 2 + lat + int'(n));
    chk({tag, " busy cycles"}, bn, (n == 0) ? 0 : lat + int'(n) + 1);
    chk({tag, " neg_count"}, neg, exp_neg);
  endtask

  // Abort raised in c0+3, two cycles after the first read strobe.
  task automatic check_abort(input string tag, input int lat, input int c0,
                             input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input ev_t rq[$], input ev_t wq[$], input int dq[$],
                             input logic [AW:0] neg);
    int exp_neg;
    exp_neg = int'(mem[s][31]) + int'(mem[s + AW'(1)][31]);
    chk({tag, " abort reads 2..3"}, (rq.size() >= 2) && (rq.size() <= 3), 1);
    chk({tag, " abort writes <=2"}, wq.size() <= 2, 1);
    for (int i = 0; i < rq.size(); i++)
      chk({tag, " abort read"}, rq[i], ev_t'{c0 + 1 + i, s + AW'(i), 32'h0});
    for (int i = 0; i < wq.size(); i++) begin
      chk({tag, " abort write"}, wq[i],
          ev_t'{c0 + 2 + lat + i, d + AW'(i), relu(mem[s + AW'(i)])});
      chk({tag, " abort write before cutoff"}, wq[i].cyc <= c0 + 3, 1);
    end
    chk({tag, " abort no done"}, dq.size(), 0);
    chk({tag, " abort neg_count"}, neg, exp_neg);
  endtask

  task automatic run_batch(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] n, input bit extra, output int c0);
    clear_logs();
    @(posedge clk); #1;
    src = s; dst = d; len = n; start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    // Scramble the inputs to show the batch runs from latched values.
    start = 1'b0;
    src = AW'($urandom);
    dst = AW'($urandom);
    len = (AW+1)'($urandom);
    if (extra) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (int'(n) + 12) @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input int c0, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input logic [AW:0] n);
    check_batch({tag, "/L1"}, 1, c0, s, d, n, h[0].rd_q, h[0].wr_q, h[0].done_q,
                h[0].busy_n, h[0].ifc.neg_count);
    check_batch({tag, "/L3"}, 3, c0, s, d, n, h[1].rd_q, h[1].wr_q, h[1].done_q,
                h[1].busy_n, h[1].ifc.neg_count);
  endtask

  initial begin
    int            c0;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [AW:0]   n;

    start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1 check_idle("after reset");

    // Reference batch from the datasheet example
    mem[0] = 32'h3dcccccd; mem[1] = 32'hfdcccccd;
    mem[2] = 32'h3ddccccd; mem[3] = 32'hfccccccd;
    run_batch(10'h000, 10'h100, 11'd4, 1'b0, c0);
    check_both("basic", c0, 10'h000, 10'h100, 11'd4);
    chk("basic L1 neg=2", h[0].ifc.neg_count, 2);
    chk("basic L3 neg=2", h[1].ifc.neg_count, 2);

    // Empty batch
    run_batch(10'h005, 10'h007, 11'd0, 1'b0, c0);
    check_both("len0", c0, 10'h005, 10'h007, 11'd0);

    // Address wrap on both sides
    run_batch(10'h3FE, 10'h3FF, 11'd3, 1'b0, c0);
    check_both("wrap", c0, 10'h3FE, 10'h3FF, 11'd3);

    // Negative zero in the middle of a batch
    for (int i = 0; i < 5; i++) mem[10'h200 + i] = $urandom;
    mem[10'h202] = 32'h80000000;
    run_batch(10'h200, 10'h050, 11'd5, 1'b0, c0);
    check_both("negzero", c0, 10'h200, 10'h050, 11'd5);

    // Random batches; the second one sees a stray start while running
    for (int t = 0; t < 4; t++) begin
      s = AW'($urandom); d = AW'($urandom); n = (AW+1)'($urandom_range(1, 24));
      run_batch(s, d, n, t == 1, c0);
      check_both("random", c0, s, d, n);
    end

    // Full-size batch
    s = AW'($urandom); d = AW'($urandom);
    run_batch(s, d, 11'd1024, 1'b0, c0);
    check_both("full", c0, s, d, 11'd1024);

    // Abort two cycles after the first read
    s = AW'($urandom); d = AW'($urandom);
    clear_logs();
    @(posedge clk); #1;
    src = s; dst = d; len = 11'd8; start = 1'b1; c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort L1 busy next", h[0].ifc.busy, 0);
    chk("abort L3 busy next", h[1].ifc.busy, 0);
    repeat (12) @(posedge clk);
    #1;
    check_abort("L1", 1, c0, s, d, h[0].rd_q, h[0].wr_q, h[0].done_q, h[0].ifc.neg_count);
    check_abort("L3", 3, c0, s, d, h[1].rd_q, h[1].wr_q, h[1].done_q, h[1].ifc.neg_count);

    s = AW'($urandom); d = AW'($urandom); n = (AW+1)'($urandom_range(1, 24));
    run_batch(s, d, n, 1'b0, c0);
    check_both("after abort", c0, s, d, n);

    // Reset during DRAIN
    clear_logs();
    @(posedge clk); #1;
    src = AW'($urandom); dst = AW'($urandom); len = 11'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("drain L1 busy", h[0].ifc.busy, 1);
    chk("drain L3 busy", h[1].ifc.busy, 1);
    chk("drain L1 no read", h[0].ifc.rd_en, 0);
    chk("drain L3 no read", h[1].ifc.rd_en, 0);
    rst_n = 1'b0;
    #1 check_idle("reset in drain");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (15) @(posedge clk);
    #1;
    chk("post-reset L1 writes", h[0].wr_q.size(), 0);
    chk("post-reset L3 writes", h[1].wr_q.size(), 0);
    chk("post-reset L1 reads",  h[0].rd_q.size(), 0);
    chk("post-reset L3 reads",  h[1].rd_q.size(), 0);
    chk("post-reset L1 done",   h[0].done_q.size(), 0);
    chk("post-reset L3 done",   h[1].done_q.size(), 0);

    s = AW'($urandom); d = AW'($urandom); n = (AW+1)'($urandom_range(1, 24));
    run_batch(s, d, n, 1'b0, c0);
    check_both("after reset", c0, s, d, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/relu_seq_ctrl.md
RELU_SEQ_CTRL -- requirements
Module: relu_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, feature-map buffer address width.
REQ-002 Parameter RELU_LAT, default 1, registered latency in cycles (1..4) of the external ReLU unit from x to out.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one batch; sampled only in IDLE.
REQ-006 abort  input  1  cancel the running batch.
REQ-007 src_addr  input  ADDR_W  first read address.
REQ-008 dst_addr  input  ADDR_W  first write address.
REQ-009 length  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 neg_count  output  ADDR_W+1  count of words in the batch with bit 31 set.
REQ-013 rd_en  output  1  buffer read strobe.
REQ-014 rd_addr  output  ADDR_W  buffer read address.
REQ-015 rd_data  input  32  IEEE-754 single word; valid exactly 1 cycle after rd_en.
REQ-016 relu_x  output  32  drives ReLU input x.
REQ-017 relu_out  input  32  ReLU output, valid RELU_LAT cycles after relu_x.
REQ-018 wr_en  output  1  buffer write strobe.
REQ-019 wr_addr  output  ADDR_W  buffer write address.
REQ-020 wr_data  output  32  buffer write data.

Function
REQ-021 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE->RUN on start=1: latch src_addr, dst_addr, length; clear neg_count.
REQ-023 IDLE->DONE on start=1 with length=0; no rd_en or wr_en issued.
REQ-024 RUN: rd_en=1 every cycle, rd_addr=src+i, i=0..length-1; first rd_en in the cycle after start accepted.
REQ-025 RUN->DRAIN after read length-1 is issued.
REQ-026 relu_x SHALL equal rd_data, combinationally, in the cycle rd_data is valid.
REQ-027 Write for word i SHALL occur exactly 1+RELU_LAT cycles after read i: wr_en=1, wr_addr=dst+i, wr_data=relu_out.
REQ-028 The valid/index pipeline SHALL be 1+RELU_LAT stages deep, so one word enters and one word leaves per cycle with no bubbles.
REQ-029 DRAIN->DONE in the cycle after the final write.
REQ-030 DONE: done=1 for one cycle, then IDLE.
REQ-031 neg_count SHALL increment once per valid rd_data with bit 31=1, including 0x80000000; hold value after done until next accepted start.
REQ-032 Addresses SHALL wrap modulo 2^ADDR_W.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 abort=1 in RUN or DRAIN: next state IDLE; all pending pipeline valids cleared; no further rd_en/wr_en; no done pulse; neg_count holds.
REQ-035 abort and start together in IDLE: start wins.
REQ-036 rd_en and wr_en SHALL be 0 in IDLE and DONE.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE; busy, done, rd_en, wr_en=0; rd_addr, wr_addr, wr_data, neg_count=0; pipeline valids cleared.
REQ-038 Reset mid-batch SHALL leave no write pending after rst_n deasserts.

Verification
REQ-039 RELU_LAT=1, src=0, dst=0x100, length=4, buffer {0x3dcccccd, 0xfdcccccd, 0x3ddccccd, 0xfccccccd} -> writes 0x100..0x103 = {0x3dcccccd, 0, 0x3ddccccd, 0}; neg_count=2; done 1 cycle after the last write.
REQ-040 length=0 -> done pulses the cycle after start; no rd_en or wr_en.
REQ-041 src=0x3FE, dst=0x3FF, length=3 -> reads 0x3FE, 0x3FF, 0x000; writes 0x3FF, 0x000, 0x001.
REQ-042 abort 2 cycles after the first rd_en, length=8 -> at most 2 writes, no done, busy low the next cycle; a new start runs cleanly.
REQ-043 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately; no wr_en after release.
REQ-044 RELU_LAT=3, length=5, word 0x80000000 -> written as 0x00000000; counted in neg_count; 5 back-to-back writes, each 4 cycles after its read.
